// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication sequencer: ALU op
// encodings, the Fermat-inversion exponent and the sequencer state type.
package ecc_pkg;

  localparam int SCALAR_W = 255;
  localparam int IDX_W    = 8;

  localparam logic [1:0] ALU_OP_PRECAL = 2'd0;
  localparam logic [1:0] ALU_OP_DOUBLE = 2'd1;
  localparam logic [1:0] ALU_OP_DIVINV = 2'd2;
  localparam logic [1:0] ALU_OP_DIVMUL = 2'd3;

  // q - 2 = 2^255 - 21: all ones except the low five bits 01011
  localparam logic [254:0] EXP_QM2 = {{250{1'b1}}, 5'b01011};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_MULT,
    S_INV,
    S_DIVMUL,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/msb_finder.sv
// Combinational priority encoder: index of the highest set bit plus an
// all-zero flag. Only needed for leading-zero skipping, so the module only
// exists when ECC_SEQ_SKIP_LZ_EN is defined.
`ifdef ECC_SEQ_SKIP_LZ_EN
module msb_finder #(
  parameter int W     = 255,
  parameter int IDX_W = 8
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_msb,
  output logic             o_zero
);

  // ascending scan so the last (highest) set bit wins
  always_comb begin
    o_msb = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_msb = IDX_W'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule
`endif

// File: rtl/ecc_sequencer.sv
// Drives the point-arithmetic ALU through one scalar multiplication:
// PRE_CAL, MSB-first double-and-add ladder, Fermat inversion ladder, DIVMUL.
// Each phase is issued with a one-cycle alu_valid pulse; inside a ladder the
// ALU chains on its own and only the registered flags advance per ready.
// Build option: define ECC_SEQ_SKIP_LZ_EN to start the multiply ladder at
// the highest set scalar bit (and skip it entirely for k = 0).
module ecc_sequencer #(
  parameter int SCALAR_W = ecc_pkg::SCALAR_W,
  parameter int IDX_W    = ecc_pkg::IDX_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [SCALAR_W-1:0] i_scalar,
  input  logic                i_alu_ready,
  output logic                o_alu_valid,
  output logic [1:0]          o_alu_state,
  output logic                o_alu_keep_flag,
  output logic                o_alu_consecutive_flag,
  output logic                o_busy,
  output logic                o_done,
  output logic [IDX_W-1:0]    o_bit_idx
);
  import ecc_pkg::*;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(SCALAR_W - 1);

  seq_state_t          r_state;
  logic                r_issue;
  logic [SCALAR_W-1:0] r_k;
  logic [IDX_W-1:0]    r_idx;
  logic                r_alu_valid;
  logic [1:0]          r_alu_state;
  logic                r_keep;
  logic                r_cons;
  logic                r_busy;
  logic                r_done;

  logic [IDX_W-1:0]    w_idx_dec;
  logic [IDX_W-1:0]    w_mult_top;
  logic                w_mult_skip;

  assign w_idx_dec = r_idx - IDX_W'(1);

`ifdef ECC_SEQ_SKIP_LZ_EN
  logic w_k_zero;

  msb_finder #(
    .W     (SCALAR_W),
    .IDX_W (IDX_W)
  ) u_msb_finder (
    .i_vec  (r_k),
    .o_msb  (w_mult_top),
    .o_zero (w_k_zero)
  );

  assign w_mult_skip = w_k_zero;
`else
  assign w_mult_top  = TOP_IDX;
  assign w_mult_skip = 1'b0;
`endif

  // Phase FSM; issue substate is the single cycle flagged by r_issue.
  // Flags only move on the edge that consumes alu_ready, so the ALU sees the
  // next bit's flags from the first cycle of the chained operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_issue     <= 1'b0;
      r_k         <= '0;
      r_idx       <= '0;
      r_alu_valid <= 1'b0;
      r_alu_state <= 2'd0;
      r_keep      <= 1'b0;
      r_cons      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_alu_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k         <= i_scalar;
            r_busy      <= 1'b1;
            r_state     <= S_PRE;
            r_issue     <= 1'b1;
            r_alu_valid <= 1'b1;
            r_alu_state <= ALU_OP_PRECAL;
            r_idx       <= '0;
            r_keep      <= 1'b0;
            r_cons      <= 1'b0;
          end
        end
        S_PRE: begin
          if (r_issue) begin
            r_issue <= 1'b0;
          end else if (i_alu_ready) begin
            r_issue     <= 1'b1;
            r_alu_valid <= 1'b1;
            if (w_mult_skip) begin
              r_state     <= S_INV;
              r_alu_state <= ALU_OP_DIVINV;
              r_idx       <= TOP_IDX;
              r_cons      <= EXP_QM2[TOP_IDX];
              r_keep      <= (TOP_IDX != '0);
            end else begin
              r_state     <= S_MULT;
              r_alu_state <= ALU_OP_DOUBLE;
              r_idx       <= w_mult_top;
              r_cons      <= r_k[w_mult_top];
              r_keep      <= (w_mult_top != '0);
            end
          end
        end
        S_MULT: begin
          if (r_issue) begin
            r_issue <= 1'b0;
          end else if (i_alu_ready) begin
            if (r_idx != '0) begin
              r_idx  <= w_idx_dec;
              r_cons <= r_k[w_idx_dec];
              r_keep <= (w_idx_dec != '0);
            end else begin
              r_state     <= S_INV;
              r_issue     <= 1'b1;
              r_alu_valid <= 1'b1;
              r_alu_state <= ALU_OP_DIVINV;
              r_idx       <= TOP_IDX;
              r_cons      <= EXP_QM2[TOP_IDX];
              r_keep      <= (TOP_IDX != '0);
            end
          end
        end
        S_INV: begin
          if (r_issue) begin
            r_issue <= 1'b0;
          end else if (i_alu_ready) begin
            if (r_idx != '0) begin
              r_idx  <= w_idx_dec;
              r_cons <= EXP_QM2[w_idx_dec];
              r_keep <= (w_idx_dec != '0);
            end else begin
              r_state     <= S_DIVMUL;
              r_issue     <= 1'b1;
              r_alu_valid <= 1'b1;
              r_alu_state <= ALU_OP_DIVMUL;
              r_cons      <= 1'b0;
              r_keep      <= 1'b0;
            end
          end
        end
        S_DIVMUL: begin
          if (r_issue) begin
            r_issue <= 1'b0;
          end else if (i_alu_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_issue <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_alu_valid            = r_alu_valid;
  assign o_alu_state            = r_alu_state;
  assign o_alu_keep_flag        = r_keep;
  assign o_alu_consecutive_flag = r_cons;
  assign o_busy                 = r_busy;
  assign o_done                 = r_done;
  assign o_bit_idx              = r_idx;

endmodule

// File: tb/tb_ecc_sequencer.sv
// Scoreboard bench for ecc_sequencer with a cycle-level ALU model.
// Stimulus pushes, per scalar, the expected flag tuple for every ALU ready
// pulse and the expected done cycle / issue count; a monitor pops and checks.
// Honours ECC_SEQ_SKIP_LZ_EN to match the DUT build.
module tb_ecc_sequencer;
  localparam int KW = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          alu_ready = 1'b0;
  logic          inj = 1'b0;
  logic [KW-1:0] scalar = '0;
  logic          alu_valid, keep, cons, busy, done;
  logic [1:0]    alu_state;
  logic [7:0]    bit_idx;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {int st; int cons; int keep; int idx;} rdy_t;
  typedef struct {int done_cyc; int n_valid;} run_t;
  rdy_t rdy_q[$];
  run_t run_q[$];

  ecc_sequencer dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_start                (start),
    .i_scalar               (scalar),
    .i_alu_ready            (alu_ready),
    .o_alu_valid            (alu_valid),
    .o_alu_state            (alu_state),
    .o_alu_keep_flag        (keep),
    .o_alu_consecutive_flag (cons),
    .o_busy                 (busy),
    .o_done                 (done),
    .o_bit_idx              (bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ALU operation latencies (cycles from start of op to its ready pulse)
  function automatic int alu_lat(input logic [1:0] st, input logic c);
    case (st)
      2'd0:    return 8;
      2'd1:    return c ? 27 : 14;
      2'd2:    return 8;
      default: return 6;
    endcase
  endfunction

  function automatic logic [KW-1:0] rand_k();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
    return t[KW-1:0];
  endfunction

  // Reference model: expected ready-pulse sequence and done timing for k,
  // accepted at cycle c0.
  task automatic push_run(input logic [KW-1:0] k, input int c0);
    int top, first, d;
    logic [KW-1:0] e;
    top = -1;
    d = 0;
    for (int i = KW - 1; i >= 0; i--) begin
      if (k[i]) begin top = i; break; end
    end
`ifdef ECC_SEQ_SKIP_LZ_EN
    first = top;
`else
    first = KW - 1;
`endif
    rdy_q.push_back('{0, 0, 0, -1});
    for (int i = first; i >= 0; i--) begin
      rdy_q.push_back('{1, int'(k[i]), int'(i != 0), i});
      d += 14 + 13 * int'(k[i]);
    end
    e = '1;
    e = e - 255'd20;
    for (int i = KW - 1; i >= 0; i--) rdy_q.push_back('{2, int'(e[i]), int'(i != 0), i});
    rdy_q.push_back('{3, 0, 0, -1});
    if (first < 0) run_q.push_back('{c0 + 2058, 3});
    else           run_q.push_back('{c0 + 2059 + d, 4});
  endtask

  // ALU model: starts an op on alu_valid, chains while keep was set
  initial begin : alu_model
    bit active, chain, op_keep;
    int due, rdy_cyc;
    active = 0; chain = 0; op_keep = 0; due = 0; rdy_cyc = 0;
    forever begin
      @(negedge clk);
      alu_ready = inj;
      if (!rst_n) begin
        active = 0;
        chain  = 0;
      end else begin
        if (active && cyc == due) begin
          alu_ready = 1'b1;
          active    = 0;
          chain     = op_keep;
          rdy_cyc   = cyc;
        end else if (chain) begin
          op_keep = keep;
          due     = rdy_cyc + alu_lat(alu_state, cons);
          active  = 1;
          chain   = 0;
        end
        if (alu_valid) begin
          op_keep = keep;
          due     = cyc + alu_lat(alu_state, cons);
          active  = 1;
        end
      end
    end
  end

  // Monitor: checks flags on each consumed ready and timing on done
  initial begin : monitor
    int vcnt;
    vcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        vcnt = 0;
      end else begin
        if (alu_valid) vcnt++;
        if (alu_ready && busy && !alu_valid) begin
          if (rdy_q.size() == 0) begin
            chk("ready_unexpected", 1, 0);
          end else begin
            rdy_t r;
            int act, exp;
            r = rdy_q.pop_front();
            act = int'(alu_state) * 100000 + int'(cons) * 10000 + int'(keep) * 1000
                + ((r.idx < 0) ? 0 : int'(bit_idx));
            exp = r.st * 100000 + r.cons * 10000 + r.keep * 1000
                + ((r.idx < 0) ? 0 : r.idx);
            chk("ready_flags_st_cons_keep_idx", longint'(act), longint'(exp));
          end
        end
        if (done) begin
          if (run_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            run_t r;
            r = run_q.pop_front();
            chk("done_cycle", longint'(cyc), longint'(r.done_cyc));
            chk("valid_pulses", longint'(vcnt), longint'(r.n_valid));
            chk("busy_low_at_done", longint'(busy), 0);
          end
          vcnt = 0;
        end
      end
    end
  end

  // One scalar multiplication; optional start poke mid-MULT or reset mid-INV
  task automatic run(input logic [KW-1:0] k, input bit poke, input bit rst_mid);
    int n, t_rst;
    @(negedge clk);
    start  = 1'b1;
    scalar = k;
    push_run(k, cyc);
    t_rst = run_q[$].done_cyc - 1000;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 12000) begin
      if (poke && n == 20) begin
        start  = 1'b1;
        scalar = ~k;
      end else begin
        start = 1'b0;
      end
      if (rst_mid && cyc == t_rst) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            longint'({alu_valid, alu_state, keep, cons, busy, done, bit_idx}), 0);
        rdy_q.delete();
        run_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", longint'(done), 1);
    @(negedge clk);
  endtask

  initial begin : stim
    logic [KW-1:0] ones;
    ones = '1;
    #12;
    chk("reset_outputs",
        longint'({alu_valid, alu_state, keep, cons, busy, done, bit_idx}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignores_ready", longint'({busy, alu_valid}), 0);
    end
    run(KW'(1), 1'b0, 1'b0);
    run('0, 1'b0, 1'b0);
    run(ones, 1'b0, 1'b0);
    run(rand_k(), 1'b1, 1'b0);
    run(KW'($urandom_range(1, 1000)), 1'b0, 1'b0);
    run(rand_k(), 1'b0, 1'b1);
    run(rand_k(), 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", longint'(rdy_q.size() + run_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
